// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Multi-cycle WIDTH-bit unsigned adder. Operand nibbles pass through
//            one shared 4-bit carry-lookahead slice, LSB nibble first, one
//            nibble per clock. The inter-nibble carry is held in a register.
// Ports    : clk      - clock, rising edge
//            rst_n    - synchronous active-low reset
//            start_i  - request, accepted in IDLE or DONE
//            a_i/b_i  - operands, sampled on the accept edge only
//            ci_i     - carry-in to nibble 0, sampled on the accept edge only
//            busy_o   - high while the add is in progress
//            done_o   - one-cycle pulse, s_o/co_o are final
//            s_o      - sum register (partial values visible while busy)
//            co_o     - carry-out of the MSB nibble
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    localparam int N  = WIDTH / NIB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    // Elaboration guard: the slice is hard-wired to 4 bits and the operand
    // must split into whole nibbles.
    generate
        if ((NIB != 4) || (WIDTH < NIB) || ((WIDTH % NIB) != 0)) begin : g_bad_param
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4, NIB must be 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [N-1:0][NIB-1:0]     a_q, a_d;
    logic [N-1:0][NIB-1:0]     b_q, b_d;
    logic [N-1:0][NIB-1:0]     s_q, s_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      carry_q, carry_d;
    logic                      co_q, co_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    // ------------------------------------------------------------------
    // Nibble select: pick the operand nibbles addressed by the counter.
    // ------------------------------------------------------------------
    logic [NIB-1:0] w_a_nib;
    logic [NIB-1:0] w_b_nib;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                w_a_nib = a_q[i];
                w_b_nib = b_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead slice. All internal carries are formed
    // directly from generate/propagate terms and the slice carry-in.
    // ------------------------------------------------------------------
    logic [NIB-1:0] w_g;
    logic [NIB-1:0] w_p;
    logic [NIB:0]   w_c;
    logic [NIB-1:0] w_sum4;
    logic           w_c4;

    assign w_g = w_a_nib & w_b_nib;
    assign w_p = w_a_nib ^ w_b_nib;

    assign w_c[0] = carry_q;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign w_sum4 = w_p ^ w_c[NIB-1:0];
    assign w_c4   = w_c[NIB];

    // ------------------------------------------------------------------
    // State register and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update. busy/done are registered copies of
    // the state being entered, so they are glitch-free and mutually
    // exclusive.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = ci_i;
                    cnt_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ADD: begin
                // Write the current nibble in place so partial sums sit at
                // their final bit positions.
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i] = w_sum4;
                    end
                end
                carry_d = w_c4;
                if (cnt_q == C_LAST) begin
                    co_d    = w_c4;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign s_o    = s_q;
    assign co_o   = co_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder (WIDTH=16 and
//            WIDTH=4 instances). A transaction-level model predicts busy,
//            done, s and co for the 16-bit instance every cycle; directed
//            cases add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        ci;
    logic        busy, done, co;
    logic [15:0] s;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        ci4;
    logic        busy4, done4, co4;
    logic [3:0]  s4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .ci_i(ci),
        .busy_o(busy), .done_o(done), .s_o(s), .co_o(co)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .ci_i(ci4),
        .busy_o(busy4), .done_o(done4), .s_o(s4), .co_o(co4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model for the 16-bit instance: an accepted request
    // takes 4 cycles, then reports (a+b+ci) as a 17-bit result.
    // ------------------------------------------------------------------
    int          m_rem  = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_s    = '0;
    logic        m_co   = 1'b0;
    logic [16:0] m_res  = '0;
    logic        m_en   = 1'b0;

    always @(posedge clk) begin
        m_en <= 1'b1;
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_co   <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_s  <= m_res[15:0];
                m_co <= m_res[16];
            end
        end else if (start) begin
            m_res  <= {1'b0, a} + {1'b0, b} + {16'd0, ci};
            m_rem  <= 4;
            m_done <= 1'b0;
            m_s    <= '0;
            m_co   <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
            check("done", {31'd0, done}, {31'd0, m_done});
            if (m_rem == 0) begin
                check("s", {16'd0, s}, {16'd0, m_s});
                check("co", {31'd0, co}, {31'd0, m_co});
            end
        end
    end

    // Wait (bounded) for done on the 16-bit instance, then check literals.
    task automatic wait_done_check(input string name, input logic [15:0] exp_s, input logic exp_co);
        bit seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_s"}, {16'd0, s}, {16'd0, exp_s});
        check({name, "_co"}, {31'd0, co}, {31'd0, exp_co});
        check({name, "_model_s"}, {16'd0, m_s}, {16'd0, exp_s});
    endtask

    task automatic do_add(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tci, input logic [15:0] exp_s, input logic exp_co);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; ci = tci;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; ci = 1'b0;
        wait_done_check(name, exp_s, exp_co);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s", {16'd0, s}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s4", {28'd0, s4}, 32'h0);
        rst_n = 1'b1;

        // Zero operands; busy lasts exactly 4 cycles.
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'h0000; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("zero_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("zero_busy4", {31'd0, busy}, 32'd1);
        wait_done_check("zero", 16'h0000, 1'b0);

        // In-place partial nibble writes.
        @(negedge clk);
        start = 1'b1; a = 16'h0033; b = 16'h0033; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("part_nib0", {28'd0, s[3:0]}, 32'h6);
        @(negedge clk);
        check("part_nib1", {28'd0, s[7:4]}, 32'h6);
        wait_done_check("x33", 16'h0066, 1'b0);

        // Full carry ripple.
        do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_add("cc33", 16'hCCCC, 16'h3333, 1'b1, 16'h0000, 1'b1);

        // start held high, operands scrambled during ADD, then back-to-back.
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held_busy", {31'd0, busy}, 32'd1);
            a = $urandom; b = $urandom; ci = $urandom;
        end
        @(negedge clk);
        check("held_done", {31'd0, done}, 32'd1);
        check("held_s", {16'd0, s}, 32'h3333);
        a = 16'h1234; b = 16'h4321; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done", {31'd0, done}, 32'd0);
        wait_done_check("b2b", 16'h5556, 1'b0);

        // Reset during the 2nd ADD cycle aborts the add.
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_s", {16'd0, s}, 32'h0);
        check("abort_co", {31'd0, co}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        do_add("fresh", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);

        // WIDTH=4 instance: done one edge after accept.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("w4_busy", {31'd0, busy4}, 32'd1);
        check("w4_early_done", {31'd0, done4}, 32'd0);
        @(negedge clk);
        check("w4_done", {31'd0, done4}, 32'd1);
        check("w4_busy_off", {31'd0, busy4}, 32'd0);
        check("w4_s", {28'd0, s4}, 32'hF);
        check("w4_co", {31'd0, co4}, 32'd1);
        @(negedge clk);
        check("w4_done_drop", {31'd0, done4}, 32'd0);
        check("w4_s_hold", {28'd0, s4}, 32'hF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
